// File: rtl/ps2_scan_rx.sv
// ----------------------------------------------------------------------------
// ps2_scan_rx
//
// PS/2 keyboard receiver. Synchronises and glitch-filters the raw PS/2 clock
// and data lines. Deframes 11-bit device-to-host frames (start, 8 data bits
// LSB first, odd parity, stop). Tracks the E0 (extended), F0 (break) and
// E1 (Pause) prefixes, and emits one packed key event per completed scan
// code. The lines are only ever observed, never driven.
//
// Parameters
//   FILTER_LEN   consecutive identical samples needed before the filtered
//                clock follows the synchronised line (2..255)
//   TIMEOUT_CYC  idle cycles allowed between falling edges inside a frame
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   ps2_c        raw PS/2 clock line (asynchronous)
//   ps2_d        raw PS/2 data line (asynchronous)
//   key_event    [10] one-cycle strobe, [9] extended, [8] break,
//                [7:0] scan code; [9:0] hold until the next event
//   rx_byte      last correctly received byte, held
//   rx_byte_vld  one-cycle pulse per good byte (prefix bytes included)
//   frame_err    one-cycle pulse on parity, stop-bit or timeout error
//
// Pipeline: a falling edge of the filtered clock ("strike") on the stop bit
// in cycle N gives rx_byte_vld / frame_err in N+1 and key_event[10] in N+2.
// ----------------------------------------------------------------------------
module ps2_scan_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ps2_c,
    input  logic        ps2_d,
    output logic [10:0] key_event,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_vld,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]    FLT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;

    // Number of good bytes that follow E1 in the Pause make sequence.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    // ------------------------------------------------------------------
    // Input synchronisers. Both reset high, which is the idle level of an
    // open-collector PS/2 bus, so releasing reset never fakes an edge.
    // ------------------------------------------------------------------
    logic [1:0] c_sync;
    logic [1:0] d_sync;
    logic       c_s;
    logic       d_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2_c};
            d_sync <= {d_sync[0], ps2_d};
        end
    end

    assign c_s = c_sync[1];
    assign d_s = d_sync[1];

    // ------------------------------------------------------------------
    // Clock glitch filter. flt_cnt counts consecutive samples that differ
    // from the current filtered level fc; any sample that agrees with fc
    // restarts the count, so pulses shorter than FILTER_LEN vanish.
    // ------------------------------------------------------------------
    logic       fc;
    logic [7:0] flt_cnt;
    logic       strike;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fc      <= 1'b1;
            flt_cnt <= 8'd0;
        end else if (c_s == fc) begin
            flt_cnt <= 8'd0;
        end else if (flt_cnt == FLT_LAST) begin
            fc      <= c_s;
            flt_cnt <= 8'd0;
        end else begin
            flt_cnt <= flt_cnt + 8'd1;
        end
    end

    // Strike is the cycle in which fc is about to fall; data is taken from
    // the synchroniser in this same cycle (the device holds it stable while
    // its clock is low).
    assign strike = fc && !c_s && (flt_cnt == FLT_LAST);

    // ------------------------------------------------------------------
    // Frame FSM with timeout supervision.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 8'd0;
            par         <= 1'b0;
            to_cnt      <= '0;
            rx_byte     <= 8'd0;
            rx_byte_vld <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_byte_vld <= 1'b0;
            frame_err   <= 1'b0;

            if (state == S_IDLE) begin
                to_cnt <= '0;
                // A high start bit is line noise or a resync; stay put quietly.
                if (strike && !d_s) begin
                    state   <= S_DATA;
                    bit_cnt <= 3'd0;
                end
            end else if (strike) begin
                // A strike always beats a timeout landing in the same cycle.
                to_cnt <= '0;
                case (state)
                    S_DATA: begin
                        shift   <= {d_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par   <= d_s;
                        state <= S_STOP;
                    end
                    default: begin
                        // Odd parity: data plus parity bit carry an odd
                        // number of ones.
                        if (d_s && (^{shift, par})) begin
                            rx_byte     <= shift;
                            rx_byte_vld <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end else if (to_cnt == TO_LAST) begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
                shift     <= 8'd0;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix tracker. Works one stage behind the deframer on the held
    // rx_byte, so the event strobe lands one cycle after rx_byte_vld.
    // rx_byte_vld and frame_err are mutually exclusive by construction.
    // ------------------------------------------------------------------
    logic       ext;
    logic       brk;
    logic [2:0] skip_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip_cnt  <= 3'd0;
            key_event <= 11'd0;
        end else begin
            key_event[10] <= 1'b0;

            if (frame_err) begin
                ext      <= 1'b0;
                brk      <= 1'b0;
                skip_cnt <= 3'd0;
            end else if (rx_byte_vld) begin
                if (skip_cnt != 3'd0) begin
                    // Inside the Pause sequence: swallow silently.
                    skip_cnt <= skip_cnt - 3'd1;
                end else if (rx_byte == BYTE_E0) begin
                    ext <= 1'b1;
                end else if (rx_byte == BYTE_F0) begin
                    brk <= 1'b1;
                end else if (rx_byte == BYTE_E1) begin
                    skip_cnt <= PAUSE_TAIL;
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                end else begin
                    key_event <= {1'b1, ext, brk, rx_byte};
                    ext       <= 1'b0;
                    brk       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_scan_rx
//
// Self-checking bench for ps2_scan_rx. A PS/2 device model drives frames on
// ps2_c / ps2_d; a monitor collects every key event, good byte and frame
// error; a byte-level reference model predicts what a keyboard controller
// should report for the stream of bytes sent.
// ----------------------------------------------------------------------------
module tb_ps2_scan_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int HP          = 20;   // PS/2 half bit period in clk cycles

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rstn;
    logic        ps2_c;
    logic        ps2_d;
    logic [10:0] key_event;
    logic [7:0]  rx_byte;
    logic        rx_byte_vld;
    logic        frame_err;

    always #5 clk = ~clk;

    ps2_scan_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ps2_c      (ps2_c),
        .ps2_d      (ps2_d),
        .key_event  (key_event),
        .rx_byte    (rx_byte),
        .rx_byte_vld(rx_byte_vld),
        .frame_err  (frame_err)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- monitor ----------------
    logic [10:0] obs_ev_q[$];
    logic [7:0]  obs_byte_q[$];
    int          obs_err = 0;
    int          obs_dbl = 0;
    logic        prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            if (key_event[10]) begin
                obs_ev_q.push_back(key_event);
                if (prev_strobe) obs_dbl++;
            end
            prev_strobe = key_event[10];
            if (rx_byte_vld) obs_byte_q.push_back(rx_byte);
            if (frame_err) obs_err++;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    // Keyboard-controller view: prefixes modify the next code, E1 hides the
    // rest of the Pause sequence, errors forget any pending prefix.
    logic [10:0] exp_q[$];
    logic [7:0]  exp_byte_q[$];
    int          exp_err = 0;
    bit          m_ext = 0;
    bit          m_brk = 0;
    int          m_skip = 0;

    task automatic model_byte(input logic [7:0] b);
        exp_byte_q.push_back(b);
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
        else begin
            exp_q.push_back({1'b1, m_ext, m_brk, b});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_err();
        exp_err++;
        m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    task automatic clear_all();
        obs_ev_q.delete(); obs_byte_q.delete(); obs_err = 0; obs_dbl = 0;
        exp_q.delete(); exp_byte_q.delete(); exp_err = 0;
    endtask

    // ---------------- drivers ----------------
    // Sends the first nbits of a frame; glitch_bit >= 0 inserts a 3-cycle low
    // pulse on the clock during that bit's high phase.
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input int nbits, input int glitch_bit);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            ps2_d = fr[i];
            if (i == glitch_bit) begin
                repeat (5) @(posedge clk);
                ps2_c = 1'b0;
                repeat (3) @(posedge clk);
                ps2_c = 1'b1;
                repeat (HP - 8) @(posedge clk);
            end else begin
                repeat (HP) @(posedge clk);
            end
            ps2_c = 1'b0;
            repeat (HP) @(posedge clk);
            ps2_c = 1'b1;
        end
        ps2_d = 1'b1;
        repeat (2 * HP) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1);
        model_byte(b);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; ps2_c = 1'b1; ps2_d = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({key_event, rx_byte, rx_byte_vld, frame_err} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs: got ev=%h byte=%h vld=%b err=%b expected all 0",
                     key_event, rx_byte, rx_byte_vld, frame_err);
        end
        @(negedge clk); rstn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if ({key_event, rx_byte, rx_byte_vld, frame_err} !== 21'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got ev=%h byte=%h vld=%b err=%b expected all 0",
                     key_event, rx_byte, rx_byte_vld, frame_err);
        end
        model_reset();
    endtask

    task automatic test_single();
        clear_all();
        send_byte(8'h1D);
        checks++;
        if (obs_ev_q.size() != 1 || obs_byte_q.size() != 1) begin
            failures++;
            $display("FAIL single_counts: got events=%0d bytes=%0d expected 1 and 1",
                     obs_ev_q.size(), obs_byte_q.size());
        end else begin
            checks++;
            if (obs_ev_q[0] !== 11'h41D || obs_byte_q[0] !== 8'h1D) begin
                failures++;
                $display("FAIL single_value: got ev=%h byte=%h expected 41d and 1d",
                         obs_ev_q[0], obs_byte_q[0]);
            end
        end
        #1;
        checks++;
        if (key_event !== 11'h01D || rx_byte !== 8'h1D) begin
            failures++;
            $display("FAIL single_hold: got ev=%h byte=%h expected 01d and 1d", key_event, rx_byte);
        end
        checks++;
        if (obs_dbl != 0) begin
            failures++;
            $display("FAIL single_strobe_width: got %0d double strobes expected 0", obs_dbl);
        end
    endtask

    task automatic test_prefixes();
        logic [7:0] seq[8] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1D, 8'h00};
        logic [10:0] want[3] = '{11'h675, 11'h775, 11'h51D};
        clear_all();
        for (int i = 0; i < 7; i++) send_byte(seq[i]);
        checks++;
        if (obs_byte_q.size() != 7 || obs_ev_q.size() != 3) begin
            failures++;
            $display("FAIL prefix_counts: got bytes=%0d events=%0d expected 7 and 3",
                     obs_byte_q.size(), obs_ev_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_ev_q[i] !== want[i]) begin
                    failures++;
                    $display("FAIL prefix_event%0d: got %h expected %h", i, obs_ev_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_parity_err();
        clear_all();
        send_frame(8'h29, 1'b1, 11, -1);
        model_err();
        checks++;
        if (obs_err != 1 || obs_byte_q.size() != 0 || obs_ev_q.size() != 0) begin
            failures++;
            $display("FAIL parity_err: got errs=%0d bytes=%0d events=%0d expected 1 0 0",
                     obs_err, obs_byte_q.size(), obs_ev_q.size());
        end
        send_byte(8'h29);
        checks++;
        if (obs_ev_q.size() != 1 || obs_ev_q[0] !== 11'h429) begin
            failures++;
            $display("FAIL parity_recover: got %0d events first=%h expected 1 event 429",
                     obs_ev_q.size(), obs_ev_q.size() ? obs_ev_q[0] : 11'h0);
        end
    endtask

    task automatic test_timeout();
        clear_all();
        send_byte(8'hE0);
        send_frame(8'h55, 1'b0, 5, -1);
        repeat (TIMEOUT_CYC + 10) @(posedge clk);
        model_err();
        checks++;
        if (obs_err != 1 || obs_ev_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_err: got errs=%0d events=%0d expected 1 and 0",
                     obs_err, obs_ev_q.size());
        end
        send_byte(8'h1C);
        checks++;
        if (obs_ev_q.size() != 1 || obs_ev_q[0] !== 11'h41C) begin
            failures++;
            $display("FAIL timeout_ext_cleared: got %0d events first=%h expected 1 event 41c",
                     obs_ev_q.size(), obs_ev_q.size() ? obs_ev_q[0] : 11'h0);
        end
    endtask

    task automatic test_glitch();
        clear_all();
        @(posedge clk); ps2_c = 1'b0;
        repeat (3) @(posedge clk); ps2_c = 1'b1;
        repeat (2 * HP) @(posedge clk);
        send_frame(8'h4B, 1'b0, 11, 4);
        model_byte(8'h4B);
        checks++;
        if (obs_err != 0 || obs_ev_q.size() != 1 || obs_ev_q[0] !== 11'h44B) begin
            failures++;
            $display("FAIL glitch: got errs=%0d events=%0d first=%h expected 0 errs 1 event 44b",
                     obs_err, obs_ev_q.size(), obs_ev_q.size() ? obs_ev_q[0] : 11'h0);
        end
    endtask

    task automatic test_pause_and_reset();
        logic [7:0] seq[9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h16};
        clear_all();
        for (int i = 0; i < 9; i++) send_byte(seq[i]);
        checks++;
        if (obs_byte_q.size() != 9 || obs_ev_q.size() != 1 || obs_ev_q[0] !== 11'h416) begin
            failures++;
            $display("FAIL pause: got bytes=%0d events=%0d first=%h expected 9 bytes 1 event 416",
                     obs_byte_q.size(), obs_ev_q.size(), obs_ev_q.size() ? obs_ev_q[0] : 11'h0);
        end
        // Prefix then abort mid-frame with reset.
        send_byte(8'hE0);
        send_frame(8'h33, 1'b0, 6, -1);
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({key_event, rx_byte, rx_byte_vld, frame_err} !== 21'd0) begin
            failures++;
            $display("FAIL midframe_reset: got ev=%h byte=%h vld=%b err=%b expected all 0",
                     key_event, rx_byte, rx_byte_vld, frame_err);
        end
        @(negedge clk); rstn = 1'b1;
        model_reset();
        clear_all();
        repeat (2 * HP) @(posedge clk);
        send_byte(8'h33);
        checks++;
        if (obs_err != 0 || obs_ev_q.size() != 1 || obs_ev_q[0] !== 11'h433) begin
            failures++;
            $display("FAIL after_reset_frame: got errs=%0d events=%0d first=%h expected 0 1 433",
                     obs_err, obs_ev_q.size(), obs_ev_q.size() ? obs_ev_q[0] : 11'h0);
        end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] b;
        clear_all();
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 11);
            if (r <= 1) send_byte(8'hE0);
            else if (r <= 3) send_byte(8'hF0);
            else if (r == 4) send_byte(8'hE1);
            else if (r == 5) begin
                b = 8'($urandom_range(0, 255));
                send_frame(b, 1'b1, 11, -1);
                model_err();
            end else begin
                b = 8'($urandom_range(1, 8'hDF));
                send_byte(b);
            end
        end
        checks++;
        if (obs_err != exp_err || obs_byte_q.size() != exp_byte_q.size() ||
            obs_ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_counts: got errs=%0d bytes=%0d events=%0d expected %0d %0d %0d",
                     obs_err, obs_byte_q.size(), obs_ev_q.size(),
                     exp_err, exp_byte_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_ev_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random_event%0d: got %h expected %h", i, obs_ev_q[i], exp_q[i]);
                end
            end
            for (int i = 0; i < exp_byte_q.size(); i++) begin
                checks++;
                if (obs_byte_q[i] !== exp_byte_q[i]) begin
                    failures++;
                    $display("FAIL random_byte%0d: got %h expected %h", i, obs_byte_q[i], exp_byte_q[i]);
                end
            end
        end
        checks++;
        if (obs_dbl != 0) begin
            failures++;
            $display("FAIL random_strobe_width: got %0d double strobes expected 0", obs_dbl);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_prefixes();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_pause_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
